// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port synchronous memory between an instruction-fetch port
// and a data-access port. Every cycle it picks at most one requester, forwards
// that requester's access to the memory, and one cycle later returns the
// memory's registered read data to whoever owned the access.
//
// Data has fixed priority over fetch. A saturating starvation counter tracks
// how many cycles in a row fetch has been refused. Once the count reaches
// STARVE_LIMIT, fetch wins the next contested cycle.
//
// Ports
//   arb_clock, arb_reset_b    clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (level) and address
//   if_gnt                    fetch granted this cycle (combinational)
//   if_valid/if_rdata         fetch response, one cycle after the grant
//   d_req/d_addr/d_wen/d_wdata  data request, address, write enable, write data
//   d_gnt                     data granted this cycle (combinational)
//   d_valid/d_rdata           data response, one cycle after the grant
//                             (pulses for writes too, with d_rdata = 0)
//   mem_sel/mem_addr/mem_wen/mem_wdata  drive to the shared memory
//   mem_rdata                 memory read data, valid the cycle after a read
//   starve_cnt                current fetch-denial count (debug)

module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          arb_clock,
  input  logic          arb_reset_b,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wen,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [3:0]    starve_cnt
);

  // The owner of the access that is in flight. Writes get their own state so
  // that the response phase knows to return zero data instead of mem_rdata.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       force_if;

  assign force_if = (starve_q >= LIMIT);

  // Grants are held low while reset is asserted. This keeps the memory idle
  // even if requesters are already driving requests.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (arb_reset_b) begin
      if (if_req && (!d_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory drive. With no grant, every memory input is held at zero.
  always_comb begin
    mem_sel   = if_gnt | d_gnt;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wen   = d_wen;
      mem_wdata = d_wdata;
    end
  end

  // Next-state logic for the owner and the starvation counter. The counter
  // counts only consecutive refusals. It restarts whenever fetch is granted
  // or stops asking, and it saturates instead of wrapping.
  always_comb begin
    owner_d  = OWN_NONE;
    starve_d = '0;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt) begin
      owner_d = d_wen ? OWN_DWR : OWN_DRD;
    end
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end
  end

  // Registered state. Asserting reset drops any response still in flight.
  always_ff @(posedge arb_clock or negedge arb_reset_b) begin
    if (!arb_reset_b) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Response routing. Read data reaches a port only in that port's valid
  // cycle, so one owner never sees the other owner's data.
  always_comb begin
    if_valid = (owner_q == OWN_IF);
    d_valid  = (owner_q == OWN_DRD) || (owner_q == OWN_DWR);
    if_rdata = (owner_q == OWN_IF)  ? mem_rdata : '0;
    d_rdata  = (owner_q == OWN_DRD) ? mem_rdata : '0;
  end

  assign starve_cnt = starve_q;

endmodule
